// File: rtl/dem_dwa_encoder_if.sv
// Handshake bundle between the noise-shaping path, the DWA encoder and the
// unit-element DAC drivers. The master side feeds codes and consumes
// select vectors; the slave side is the encoder itself.
interface dem_dwa_encoder_if #(
  parameter int NUM_ELEM = 16
);
  localparam int CODE_W = $clog2(NUM_ELEM + 1);
  localparam int PTR_W  = $clog2(NUM_ELEM);

  logic [CODE_W-1:0]   code_in;
  logic                code_valid;
  logic                code_ready;
  logic                dem_en;
  logic [NUM_ELEM-1:0] elem_sel;
  logic                sel_valid;
  logic                sel_ready;
  logic [PTR_W-1:0]    ptr_out;
  logic                ovf_flag;
  logic                ovf_clr;

  modport master (
    output code_in,
    output code_valid,
    input  code_ready,
    output dem_en,
    input  elem_sel,
    input  sel_valid,
    output sel_ready,
    input  ptr_out,
    input  ovf_flag,
    output ovf_clr
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready,
    input  dem_en,
    output elem_sel,
    output sel_valid,
    input  sel_ready,
    output ptr_out,
    output ovf_flag,
    input  ovf_clr
  );
endinterface

// File: rtl/dem_dwa_encoder.sv
// Data-weighted-averaging encoder for the unit-element DAC. Each accepted
// code selects a contiguous run of elements starting at a rotating pointer,
// so every element is used equally often and mismatch error is pushed to
// high frequencies. A single registered output slot decouples the DAC side.
module dem_dwa_encoder #(
  parameter int NUM_ELEM = 16,
  parameter int CODE_W   = $clog2(NUM_ELEM + 1),
  parameter int PTR_W    = $clog2(NUM_ELEM)
) (
  input logic              clk,
  input logic              reset_n,
  dem_dwa_encoder_if.slave bus
);

  // Largest legal code: all elements on.
  localparam logic [CODE_W-1:0]   MAX_CODE = CODE_W'(NUM_ELEM);
  localparam logic [NUM_ELEM-1:0] ALL_ONES = '1;

  // Output slot occupancy.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [NUM_ELEM-1:0]   sel_q;
  logic [NUM_ELEM-1:0]   sel_next;
  logic [NUM_ELEM-1:0]   ones_mask;
  logic [2*NUM_ELEM-1:0] therm;
  logic [2*NUM_ELEM-1:0] rotated;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_next;
  logic [PTR_W-1:0]      shift_amt;
  logic [CODE_W-1:0]     code_eff;
  logic                  code_over;
  logic                  ovf_q;
  logic                  slot_full;
  logic                  can_take;
  logic                  accept;

  // The slot can take a new code when empty or when it is drained this cycle;
  // this never depends on code_in, only on slot state and sel_ready.
  assign slot_full = (state == ST_FULL);
  assign can_take  = !slot_full || bus.sel_ready;
  assign accept    = bus.code_valid && can_take;

  // Clamp out-of-range codes to full scale and note the overrange.
  always_comb begin
    code_over = (bus.code_in > MAX_CODE);
    code_eff  = code_over ? MAX_CODE : bus.code_in;
  end

  // Build a thermometer of code_eff ones in a double-width word, rotate it by
  // the pointer and fold the upper half back onto the lower half, which gives
  // the modulo-NUM_ELEM wrap in one level of logic. Static mode uses shift 0.
  always_comb begin
    ones_mask = ~(ALL_ONES << code_eff);
    therm     = {{NUM_ELEM{1'b0}}, ones_mask};
    shift_amt = bus.dem_en ? ptr_q : '0;
    rotated   = therm << shift_amt;
    sel_next  = rotated[NUM_ELEM-1:0] | rotated[2*NUM_ELEM-1:NUM_ELEM];
    ptr_next  = bus.dem_en ? (ptr_q + code_eff[PTR_W-1:0]) : ptr_q;
  end

  // Slot occupancy: fill on accept, drain only when consumed with nothing new.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (!accept && bus.sel_ready) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_next;
  end

  // Vector and pointer only move on acceptance, so they hold under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= '0;
      ptr_q <= '0;
    end else if (accept) begin
      sel_q <= sel_next;
      ptr_q <= ptr_next;
    end
  end

  // Sticky overrange flag; a new overrange wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   ovf_q <= 1'b0;
    else if (accept && code_over)   ovf_q <= 1'b1;
    else if (bus.ovf_clr)           ovf_q <= 1'b0;
  end

  assign bus.code_ready = can_take;
  assign bus.elem_sel   = sel_q;
  assign bus.sel_valid  = slot_full;
  assign bus.ptr_out    = ptr_q;
  assign bus.ovf_flag   = ovf_q;

endmodule

// File: tb/tb_dem_dwa_encoder.sv
// Scoreboard bench for the DWA encoder: expected vectors are queued when a
// code is accepted and compared while they sit in the output slot.
module tb_dem_dwa_encoder;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  dem_dwa_encoder_if #(.NUM_ELEM(N)) bus ();

  dem_dwa_encoder #(.NUM_ELEM(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [N-1:0] sel;
    logic [3:0]   ptr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;
  bit   m_full = 1'b0;
  bit   m_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  // Reference select vector built bit by bit from the element indices.
  function automatic logic [N-1:0] refSel(input int c, input int p, input bit dem);
    logic [N-1:0] v;
    int start;
    v = '0;
    start = dem ? p : 0;
    for (int i = 0; i < c; i++) v[(start + i) % N] = 1'b1;
    return v;
  endfunction

  // One clock cycle: drive, check slot contents at negedge, update the model.
  task automatic applyStimulus(input bit valid, input int code, input bit dem,
                               input bit rdy, input bit clr);
    bit   acc;
    int   c;
    exp_t e;
    bus.code_valid = valid;
    bus.code_in    = 5'(code);
    bus.dem_en     = dem;
    bus.sel_ready  = rdy;
    bus.ovf_clr    = clr;
    @(negedge clk);
    checkOutput("sel_valid", bus.sel_valid, m_full);
    checkOutput("code_ready", bus.code_ready, (!m_full || rdy));
    checkOutput("ovf_flag", bus.ovf_flag, m_ovf);
    checkOutput("ptr_now", bus.ptr_out, m_ptr);
    if (m_full) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_underflow: got=valid vector expected=none");
      end else begin
        e = sb[0];
        checkOutput("elem_sel", bus.elem_sel, e.sel);
        checkOutput("ptr_out", bus.ptr_out, e.ptr);
        if (rdy) void'(sb.pop_front());
      end
    end
    acc = valid && (!m_full || rdy);
    if (acc) begin
      c = (code > N) ? N : code;
      e.sel = refSel(c, m_ptr, dem);
      if (dem) m_ptr = (m_ptr + c) % N;
      e.ptr = 4'(m_ptr);
      sb.push_back(e);
    end
    if (acc && code > N) m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    m_full = acc ? 1'b1 : (rdy ? 1'b0 : m_full);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.code_valid = 1'b0;
    bus.code_in    = '0;
    bus.dem_en     = 1'b1;
    bus.sel_ready  = 1'b1;
    bus.ovf_clr    = 1'b0;
    #2;
    checkOutput("por_sel", bus.elem_sel, 16'h0000);
    checkOutput("por_valid", bus.sel_valid, 1'b0);
    checkOutput("por_ptr", bus.ptr_out, 4'd0);
    checkOutput("por_ovf", bus.ovf_flag, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 0, 1, 1, 0);

    // Rotation
    applyStimulus(1, 5, 1, 1, 0);
    checkOutput("rot1_sel", bus.elem_sel, 16'h001F);
    checkOutput("rot1_ptr", bus.ptr_out, 4'd5);
    applyStimulus(1, 5, 1, 1, 0);
    checkOutput("rot2_sel", bus.elem_sel, 16'h03E0);
    checkOutput("rot2_ptr", bus.ptr_out, 4'd10);
    applyStimulus(1, 5, 1, 1, 0);
    checkOutput("rot3_sel", bus.elem_sel, 16'h7C00);
    checkOutput("rot3_ptr", bus.ptr_out, 4'd15);

    // Wrap-around, full scale and zero
    applyStimulus(1, 3, 1, 1, 0);
    checkOutput("wrap_sel", bus.elem_sel, 16'h8003);
    checkOutput("wrap_ptr", bus.ptr_out, 4'd2);
    applyStimulus(1, 16, 1, 1, 0);
    checkOutput("full_sel", bus.elem_sel, 16'hFFFF);
    checkOutput("full_ptr", bus.ptr_out, 4'd2);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("zero_sel", bus.elem_sel, 16'h0000);
    checkOutput("zero_ptr", bus.ptr_out, 4'd2);

    // Overflow and flag precedence
    applyStimulus(1, 20, 1, 1, 0);
    checkOutput("ovf_sel", bus.elem_sel, 16'hFFFF);
    checkOutput("ovf_set", bus.ovf_flag, 1'b1);
    checkOutput("ovf_ptr", bus.ptr_out, 4'd2);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("ovf_clr", bus.ovf_flag, 1'b0);
    applyStimulus(1, 31, 1, 1, 1);
    checkOutput("ovf_prio", bus.ovf_flag, 1'b1);
    applyStimulus(0, 0, 1, 1, 1);

    // Backpressure
    applyStimulus(1, 7, 1, 1, 0);
    checkOutput("bp_sel0", bus.elem_sel, 16'h01FC);
    checkOutput("bp_ptr0", bus.ptr_out, 4'd9);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 3, 1, 0, 0);
      checkOutput("bp_rdy", bus.code_ready, 1'b0);
      checkOutput("bp_sel", bus.elem_sel, 16'h01FC);
      checkOutput("bp_ptr", bus.ptr_out, 4'd9);
    end

    // Static mode accepted in the same cycle as the consume, then back to DWA
    applyStimulus(1, 4, 0, 1, 0);
    checkOutput("st_sel", bus.elem_sel, 16'h000F);
    checkOutput("st_ptr", bus.ptr_out, 4'd9);
    applyStimulus(1, 2, 1, 1, 0);
    checkOutput("dwa_sel", bus.elem_sel, 16'h0600);
    checkOutput("dwa_ptr", bus.ptr_out, 4'd11);

    // Random traffic against the model
    for (int k = 0; k < 80; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 20),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0);
    end

    // Reset with a pending vector and a raised flag
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 18, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_sel", bus.elem_sel, 16'h0000);
    checkOutput("rst_valid", bus.sel_valid, 1'b0);
    checkOutput("rst_ptr", bus.ptr_out, 4'd0);
    checkOutput("rst_ovf", bus.ovf_flag, 1'b0);
    sb.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("post_rst_rdy", bus.code_ready, 1'b1);
    checkOutput("post_rst_valid", bus.sel_valid, 1'b0);
    applyStimulus(1, 5, 1, 1, 0);
    checkOutput("post_rst_sel", bus.elem_sel, 16'h001F);
    checkOutput("post_rst_ptr", bus.ptr_out, 4'd5);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
